// File: rtl/downsampler_dec.sv
// Integer-factor I/Q decimator: keeps one of every DECIM valid samples, or with
// DOWNSAMPLER_ACC_EN defined, integrates-and-dumps each DECIM-sample window with saturation.
`default_nettype none

module downsampler_dec #(
  parameter int DW    = 32,
  parameter int DECIM = 7
) (
  input  logic          fast_clk,
  input  logic          reset_n,
  input  logic          din_valid,
  input  logic [DW-1:0] din_re_Ff,
  input  logic [DW-1:0] din_im_Ff,
  input  logic          phase_clr,
  output logic          dout_valid,
  output logic [DW-1:0] dout_re_Fs,
  output logic [DW-1:0] dout_im_Fs
);

  localparam int CW = (DECIM <= 2) ? 1 : $clog2(DECIM);
  localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

  logic [CW-1:0] cnt;

  // A phase_clr with a valid sample makes that sample index 0, so the count lands on 1.
  always_ff @(posedge fast_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (phase_clr) begin
      cnt <= din_valid ? CW'(1) : '0;
    end else if (din_valid) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

`ifdef DOWNSAMPLER_ACC_EN

  localparam int AW = DW + 8;

  logic signed [AW-1:0] acc_re;
  logic signed [AW-1:0] acc_im;
  logic signed [AW-1:0] sum_re;
  logic signed [AW-1:0] sum_im;
  logic                 dump;

  function automatic logic [DW-1:0] sat(input logic signed [AW-1:0] v);
    logic [DW-1:0] r;
    if (v[AW-1:DW-1] == {(AW-DW+1){1'b0}} || v[AW-1:DW-1] == {(AW-DW+1){1'b1}})
      r = v[DW-1:0];
    else if (v[AW-1])
      r = {1'b1, {(DW-1){1'b0}}};
    else
      r = {1'b0, {(DW-1){1'b1}}};
    return r;
  endfunction

  // phase_clr discards the partial sums, so the current sample starts a fresh window.
  assign sum_re = (phase_clr ? '0 : acc_re) + {{(AW-DW){din_re_Ff[DW-1]}}, din_re_Ff};
  assign sum_im = (phase_clr ? '0 : acc_im) + {{(AW-DW){din_im_Ff[DW-1]}}, din_im_Ff};
  assign dump   = din_valid & ~phase_clr & (cnt == LAST);

  always_ff @(posedge fast_clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_re     <= '0;
      acc_im     <= '0;
      dout_re_Fs <= '0;
      dout_im_Fs <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= dump;
      if (din_valid) begin
        if (dump) begin
          dout_re_Fs <= sat(sum_re);
          dout_im_Fs <= sat(sum_im);
          acc_re     <= '0;
          acc_im     <= '0;
        end else begin
          acc_re <= sum_re;
          acc_im <= sum_im;
        end
      end else if (phase_clr) begin
        acc_re <= '0;
        acc_im <= '0;
      end
    end
  end

`else

  logic take;

  assign take = din_valid & (phase_clr | (cnt == '0));

  always_ff @(posedge fast_clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_re_Fs <= '0;
      dout_im_Fs <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= take;
      if (take) begin
        dout_re_Fs <= din_re_Ff;
        dout_im_Fs <= din_im_Ff;
      end
    end
  end

`endif

endmodule

`default_nettype wire

// File: tb/tb_downsampler_dec.sv
// Self-checking bench for downsampler_dec: scoreboard on streaming traffic plus
// cycle-exact vector tables for phase_clr corners; honours DOWNSAMPLER_ACC_EN.
`default_nettype none

module tb_downsampler_dec;

  localparam int DW    = 32;
  localparam int DECIM = 7;

  logic          fast_clk = 1'b0;
  logic          reset_n;
  logic          din_valid;
  logic          phase_clr;
  logic [DW-1:0] din_re_Ff;
  logic [DW-1:0] din_im_Ff;
  logic          dout_valid;
  logic [DW-1:0] dout_re_Fs;
  logic [DW-1:0] dout_im_Fs;

  downsampler_dec #(.DW(DW), .DECIM(DECIM)) dut (
    .fast_clk   (fast_clk),
    .reset_n    (reset_n),
    .din_valid  (din_valid),
    .din_re_Ff  (din_re_Ff),
    .din_im_Ff  (din_im_Ff),
    .phase_clr  (phase_clr),
    .dout_valid (dout_valid),
    .dout_re_Fs (dout_re_Fs),
    .dout_im_Fs (dout_im_Fs)
  );

  always #5 fast_clk = ~fast_clk;

  typedef struct {
    logic        v;
    logic        clr;
    logic [31:0] re;
    logic        ev;
    logic [31:0] ere;
    logic        cmp;
  } vec_t;

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
  } samp_t;

  vec_t  tbl[$];
  samp_t sbq[$];
  int    strobe_cyc[$];

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          m_cnt = 0;
  longint      m_acc_re = 0;
  longint      m_acc_im = 0;
  logic        m_strobe = 1'b0;
  logic [31:0] hold_re  = '0;
  logic [31:0] hold_im  = '0;

  function automatic logic [31:0] sat32(input longint v);
    logic [31:0] r;
    if (v > 64'sd2147483647)       r = 32'h7FFF_FFFF;
    else if (v < -64'sd2147483648) r = 32'h8000_0000;
    else                           r = v[31:0];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt    = 0;
    m_acc_re = 0;
    m_acc_im = 0;
    m_strobe = 1'b0;
    hold_re  = '0;
    hold_im  = '0;
    sbq.delete();
  endtask

  // Drive one cycle, advance the reference model, then check the cycle's outputs.
  task automatic cycle(input logic v, input logic clr, input logic [31:0] re, input logic [31:0] im);
    samp_t s;
    din_valid = v;
    phase_clr = clr;
    din_re_Ff = re;
    din_im_Ff = im;
    m_strobe  = 1'b0;
    if (clr) begin
      m_cnt    = 0;
      m_acc_re = 0;
      m_acc_im = 0;
    end
    if (v) begin
`ifdef DOWNSAMPLER_ACC_EN
      m_acc_re += longint'($signed(re));
      m_acc_im += longint'($signed(im));
      if (m_cnt == DECIM - 1) begin
        s.re = sat32(m_acc_re);
        s.im = sat32(m_acc_im);
        sbq.push_back(s);
        m_strobe = 1'b1;
        m_acc_re = 0;
        m_acc_im = 0;
      end
`else
      if (m_cnt == 0) begin
        s.re = re;
        s.im = im;
        sbq.push_back(s);
        m_strobe = 1'b1;
      end
`endif
      m_cnt = (m_cnt == DECIM - 1) ? 0 : m_cnt + 1;
    end
    @(posedge fast_clk);
    #1;
    cyc++;
    check("strobe", {31'd0, dout_valid}, {31'd0, m_strobe});
    if (dout_valid === 1'b1) begin
      strobe_cyc.push_back(cyc);
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow cycle=%0d actual=strobe required=none", cyc);
      end else begin
        s = sbq.pop_front();
        check("sb_re", dout_re_Fs, s.re);
        check("sb_im", dout_im_Fs, s.im);
        hold_re = s.re;
        hold_im = s.im;
      end
    end else begin
      check("hold_re", dout_re_Fs, hold_re);
      check("hold_im", dout_im_Fs, hold_im);
    end
  endtask

  task automatic add(input logic v, input logic clr, input logic [31:0] re,
                     input logic ev, input logic [31:0] ere, input logic cmp);
    vec_t e;
    e.v = v; e.clr = clr; e.re = re; e.ev = ev; e.ere = ere; e.cmp = cmp;
    tbl.push_back(e);
  endtask

  task automatic check_spacing(input string name, input int exp_n, input int exp_gap);
    check({name, "_count"}, strobe_cyc.size(), exp_n);
    for (int k = 1; k < strobe_cyc.size(); k++)
      check({name, "_gap"}, strobe_cyc[k] - strobe_cyc[k-1], exp_gap);
    strobe_cyc.delete();
  endtask

  initial begin
    int n_strobes;
`ifdef DOWNSAMPLER_ACC_EN
    n_strobes = 11;
    for (int i = 0; i < 6; i++) add(1'b1, i == 0, i, 1'b0, 0, 1'b0);
    add(1'b1, 1'b0, 6, 1'b1, 21, 1'b1);
    for (int i = 7; i < 13; i++) add(1'b1, 1'b0, i, 1'b0, 21, 1'b1);
    add(1'b1, 1'b0, 13, 1'b1, 70, 1'b1);
    add(1'b1, 1'b0, 1, 1'b0, 70, 1'b1);
    add(1'b1, 1'b0, 1, 1'b0, 70, 1'b1);
    add(1'b1, 1'b1, 5, 1'b0, 70, 1'b1);
    for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 1, 1'b0, 70, 1'b1);
    add(1'b1, 1'b0, 1, 1'b1, 11, 1'b1);
`else
    n_strobes = 12;
    add(1'b1, 1'b1, 0, 1'b1, 0, 1'b1);
    for (int i = 1; i < 7; i++) add(1'b1, 1'b0, i, 1'b0, 0, 1'b1);
    add(1'b1, 1'b0, 7, 1'b1, 7, 1'b1);
    for (int i = 8; i < 10; i++) add(1'b1, 1'b0, i, 1'b0, 7, 1'b1);
    add(1'b1, 1'b1, 10, 1'b1, 10, 1'b1);
    for (int i = 11; i < 17; i++) add(1'b1, 1'b0, i, 1'b0, 10, 1'b1);
    add(1'b1, 1'b0, 17, 1'b1, 17, 1'b1);
    for (int i = 18; i < 21; i++) add(1'b1, 1'b0, i, 1'b0, 17, 1'b1);
    add(1'b0, 1'b1, 0, 1'b0, 17, 1'b1);
    add(1'b0, 1'b0, 0, 1'b0, 17, 1'b1);
    add(1'b1, 1'b0, 30, 1'b1, 30, 1'b1);
    add(1'b1, 1'b0, 31, 1'b0, 30, 1'b1);
`endif

    reset_n   = 1'b0;
    din_valid = 1'b0;
    phase_clr = 1'b0;
    din_re_Ff = '0;
    din_im_Ff = '0;
    repeat (3) @(posedge fast_clk);
    #1;
    check("rst_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_re", dout_re_Fs, 32'd0);
    check("rst_im", dout_im_Fs, 32'd0);
    reset_n = 1'b1;
    model_reset();

    for (int i = 0; i < 80; i++) cycle(1'b1, 1'b0, i, -i);
    check_spacing("dense", n_strobes, DECIM);

    for (int i = 0; i < 80; i++) begin
      cycle(1'b1, i == 0, i, -i);
      cycle(1'b0, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    end
    check_spacing("sparse", n_strobes, 2 * DECIM);

    foreach (tbl[k]) begin
      cycle(tbl[k].v, tbl[k].clr, tbl[k].re, -tbl[k].re);
      check("tbl_valid", {31'd0, dout_valid}, {31'd0, tbl[k].ev});
      if (tbl[k].cmp) begin
        check("tbl_re", dout_re_Fs, tbl[k].ere);
        check("tbl_im", dout_im_Fs, -tbl[k].ere);
      end
    end
    strobe_cyc.delete();

    for (int i = 0; i < 10; i++) cycle(1'b1, i == 0, i, -i);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_valid", {31'd0, dout_valid}, 32'd0);
    check("async_re", dout_re_Fs, 32'd0);
    check("async_im", dout_im_Fs, 32'd0);
    @(posedge fast_clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, 100 + i, -(100 + i));
    strobe_cyc.delete();

    for (int i = 0; i < DECIM; i++) cycle(1'b1, i == 0, 32'h7FFF_FFFF, 32'h8000_0000);
    cycle(1'b0, 1'b0, 0, 0);
    check("sat_re", dout_re_Fs, 32'h7FFF_FFFF);
    check("sat_im", dout_im_Fs, 32'h8000_0000);

    check("sb_leftover", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
